// File: rtl/mem_access_stage_if.sv
// EX/MEM -> MEM stage bundle: decoded controls in,
// branch resolution, stall and MEM/WB registers out.
interface mem_access_stage_if;
  logic [1:0]  WB;
  logic        Branch;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] BranchInst;
  logic        ZeroFlag;
  logic [31:0] ALUresult;
  logic [31:0] Dato2;
  logic [4:0]  DirWriteReg;
  logic        PCSrc;
  logic [31:0] O_BranchTarget;
  logic        Stall;
  logic [1:0]  O_WB;
  logic [31:0] O_ReadData;
  logic [31:0] O_ALUresult;
  logic [4:0]  O_DirWriteReg;

  modport master (
    output WB, Branch, MemWrite, MemRead,
    output BranchInst, ZeroFlag, ALUresult,
    output Dato2, DirWriteReg,
    input  PCSrc, O_BranchTarget, Stall,
    input  O_WB, O_ReadData, O_ALUresult,
    input  O_DirWriteReg
  );

  modport slave (
    input  WB, Branch, MemWrite, MemRead,
    input  BranchInst, ZeroFlag, ALUresult,
    input  Dato2, DirWriteReg,
    output PCSrc, O_BranchTarget, Stall,
    output O_WB, O_ReadData, O_ALUresult,
    output O_DirWriteReg
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: branch resolution, multi-cycle data
// memory access with upstream stall, MEM/WB register.
module mem_access_stage #(
  parameter int DEPTH = 64,
  parameter int LAT   = 2
) (
  input logic clk,
  input logic reset,
  mem_access_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  logic           stall;
  logic           done;
  logic           access;
  logic [AW-1:0]  idx;
  logic [31:0]    mem [DEPTH];

  assign access = bus.MemRead | bus.MemWrite;
  assign idx    = bus.ALUresult[AW+1:2];

  assign bus.PCSrc          = bus.Branch & bus.ZeroFlag;
  assign bus.O_BranchTarget = bus.BranchInst;
  assign bus.Stall          = stall;

  // done marks the cycle whose edge retires the instruction
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    done      = 1'b1;
    unique case (state)
      IDLE: begin
        if (access && (LAT > 1)) begin
          stall     = 1'b1;
          done      = 1'b0;
          state_nxt = WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      WAIT: begin
        if (cnt != CW'(LAT - 1)) begin
          stall   = 1'b1;
          done    = 1'b0;
          cnt_nxt = cnt + CW'(1);
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      bus.O_WB          <= '0;
      bus.O_ReadData    <= '0;
      bus.O_ALUresult   <= '0;
      bus.O_DirWriteReg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (done) begin
        bus.O_WB          <= bus.WB;
        bus.O_ALUresult   <= bus.ALUresult;
        bus.O_DirWriteReg <= bus.DirWriteReg;
        // store wins when both controls are set
        bus.O_ReadData    <=
          (bus.MemRead && !bus.MemWrite) ?
          mem[idx] : '0;
      end else begin
        bus.O_WB          <= '0;
        bus.O_ReadData    <= '0;
        bus.O_ALUresult   <= '0;
        bus.O_DirWriteReg <= '0;
      end
    end
  end

  // array is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (done && bus.MemWrite && !reset)
      mem[idx] <= bus.Dato2;
  end
endmodule
